// File: rtl/buscaminas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buscaminas_pkg
// Description : Shared types and constants for the Buscaminas game controller.
//               Holds the FSM state encoding, the pending action kind and the
//               bit layout of a board RAM cell word {flag, revealed, mine}.
// Revision    : 1.0 - initial release
// ============================================================================
package buscaminas_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  typedef enum logic {
    ACT_REVEAL = 1'b0,
    ACT_FLAG   = 1'b1
  } action_t;

  localparam int CELL_W    = 3;
  localparam int CELL_MINE = 0;
  localparam int CELL_REV  = 1;
  localparam int CELL_FLAG = 2;

endpackage
`default_nettype wire

// File: rtl/turn_timer.sv
`default_nettype none
// ============================================================================
// Module      : turn_timer
// Description : Counts idle cycles of a turn. expired is asserted in the
//               enabled cycle that would be the TURN_CYCLES-th idle cycle.
//               With TURN_CYCLES == 0 the timer is removed and never expires.
// Ports       : clk, rst (async, active-high)
//               clear   - restart the count (has priority over enable)
//               enable  - count this cycle
//               expired - combinational, enable && count == TURN_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module turn_timer #(
  parameter int TURN_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TURN_CYCLES > 0) begin : g_timer
      localparam int W = $clog2(TURN_CYCLES + 1);
      logic [W-1:0] count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable) begin
          count <= count + 1'b1;
        end
      end

      assign expired = enable && (count == W'(TURN_CYCLES - 1));
    end else begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable};
      assign expired       = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/buscaminas_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : buscaminas_game_ctrl
// Description : Buscaminas game controller for a ROWS x COLS board. Owns the
//               cursor, turn timeout, revealed-cell count and win/lose
//               decisions; reads/updates cells in an external 1-cycle RAM.
// Ports       : clk, rst (async, active-high)
//               start, mines_cfg            - game start / board mine count
//               btn_up/down/left/right      - cursor move pulses
//               btn_reveal, btn_flag        - cell action pulses
//               cell_addr                   - cursor address (row*COLS+col)
//               cell_rd_data                - {flag,revealed,mine}, 1-cycle latency
//               cell_wr_en, cell_wr_data    - cell update strobe and word
//               cursor_row, cursor_col      - cursor position
//               revealed_cnt                - safe cells revealed this game
//               idle, win, lose, timeout    - status
//               cfg_err                     - rejected start pulse
// Revision    : 1.0 - initial release
// ============================================================================
module buscaminas_game_ctrl
  import buscaminas_pkg::*;
#(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int TURN_CYCLES = 0,
  parameter int ADDR_W      = $clog2(ROWS * COLS),
  parameter int CNT_W       = $clog2(ROWS * COLS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         mines_cfg,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_reveal,
  input  logic                     btn_flag,
  output logic [ADDR_W-1:0]        cell_addr,
  input  logic [CELL_W-1:0]        cell_rd_data,
  output logic                     cell_wr_en,
  output logic [CELL_W-1:0]        cell_wr_data,
  output logic [$clog2(ROWS)-1:0]  cursor_row,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic [CNT_W-1:0]         revealed_cnt,
  output logic                     idle,
  output logic                     win,
  output logic                     lose,
  output logic                     timeout,
  output logic                     cfg_err
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_PLAY  = PLAY;
  localparam logic [2:0] ST_READ  = READ;
  localparam logic [2:0] ST_CHECK = CHECK;
  localparam logic [2:0] ST_WIN   = WIN;
  localparam logic [2:0] ST_LOSE  = LOSE;

  logic [2:0]       state;
  action_t          action;
  logic [CNT_W-1:0] safe_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             cfg_ok;
  logic             play_act;
  logic             tmr_clear;
  logic             tmr_en;
  logic             tmr_expired;
  logic             reveal_ok;

  assign cell_addr = ADDR_W'(cursor_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);
  assign idle      = (state == ST_IDLE);
  assign cfg_ok    = (mines_cfg != '0) && (mines_cfg < CNT_W'(ROWS * COLS));
  assign next_cnt  = revealed_cnt + 1'b1;
  assign play_act  = (state == ST_PLAY) &&
                     (btn_reveal || btn_flag || btn_up || btn_down || btn_left || btn_right);

  // The timer only runs on idle PLAY cycles; READ/CHECK neither count nor clear.
  assign tmr_clear = (state == ST_IDLE && start && cfg_ok) || play_act;
  assign tmr_en    = (state == ST_PLAY) && !play_act;

  turn_timer #(
    .TURN_CYCLES (TURN_CYCLES)
  ) u_turn_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // A reveal only takes effect on a hidden, unflagged cell.
  assign reveal_ok = !cell_rd_data[CELL_FLAG] && !cell_rd_data[CELL_REV];

  // The write is combinational in CHECK so that an asynchronous reset taken
  // during CHECK kills the strobe in the same cycle.
  always_comb begin
    cell_wr_en   = 1'b0;
    cell_wr_data = cell_rd_data;
    if (state == ST_CHECK) begin
      if (action == ACT_REVEAL) begin
        if (reveal_ok) begin
          cell_wr_en             = 1'b1;
          cell_wr_data[CELL_REV] = 1'b1;
        end
      end else if (!cell_rd_data[CELL_REV]) begin
        cell_wr_en              = 1'b1;
        cell_wr_data[CELL_FLAG] = ~cell_rd_data[CELL_FLAG];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      action       <= ACT_REVEAL;
      safe_cnt     <= '0;
      revealed_cnt <= '0;
      cursor_row   <= '0;
      cursor_col   <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
      timeout      <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state        <= ST_PLAY;
              safe_cnt     <= CNT_W'(ROWS * COLS) - mines_cfg;
              revealed_cnt <= '0;
              cursor_row   <= '0;
              cursor_col   <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (btn_reveal) begin
            action <= ACT_REVEAL;
            state  <= ST_READ;
          end else if (btn_flag) begin
            action <= ACT_FLAG;
            state  <= ST_READ;
          end else if (btn_up) begin
            cursor_row <= (cursor_row == '0) ? ROW_W'(ROWS - 1) : cursor_row - 1'b1;
          end else if (btn_down) begin
            cursor_row <= (cursor_row == ROW_W'(ROWS - 1)) ? '0 : cursor_row + 1'b1;
          end else if (btn_left) begin
            cursor_col <= (cursor_col == '0) ? COL_W'(COLS - 1) : cursor_col - 1'b1;
          end else if (btn_right) begin
            cursor_col <= (cursor_col == COL_W'(COLS - 1)) ? '0 : cursor_col + 1'b1;
          end else if (tmr_expired) begin
            state   <= ST_LOSE;
            lose    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        ST_READ: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          state <= ST_PLAY;
          if (action == ACT_REVEAL && reveal_ok) begin
            if (cell_rd_data[CELL_MINE]) begin
              state <= ST_LOSE;
              lose  <= 1'b1;
            end else begin
              revealed_cnt <= next_cnt;
              if (next_cnt == safe_cnt) begin
                state <= ST_WIN;
                win   <= 1'b1;
              end
            end
          end
        end
        ST_WIN, ST_LOSE: begin
          if (start) begin
            state   <= ST_IDLE;
            win     <= 1'b0;
            lose    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buscaminas_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_buscaminas_game_ctrl
// Description : Self-checking bench for buscaminas_game_ctrl on a 4x4 board
//               with a single mine at address 5 and a 10-cycle turn timeout.
//               Expected RAM writes, win/lose rises and cfg_err pulses are
//               queued by the stimulus and matched by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buscaminas_game_ctrl;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int TURN   = 10;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;
  localparam int MINE_A = 5;

  localparam int K_WR   = 1;
  localparam int K_WIN  = 2;
  localparam int K_LOSE = 3;
  localparam int K_CFG  = 4;

  // button codes for pulse()
  localparam int B_REV = 0, B_FLAG = 1, B_UP = 2, B_DOWN = 3, B_LEFT = 4, B_RIGHT = 5, B_START = 6;

  typedef struct {
    int kind;
    int addr;
    int data;
    int tmo;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int  vecs = 0;
  int  errs = 0;
  int  cyc  = 0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] mines_cfg = '0;
  logic             btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic             btn_reveal = 1'b0, btn_flag = 1'b0;
  logic [ADDR_W-1:0] cell_addr;
  logic [2:0]       cell_rd_data;
  logic             cell_wr_en;
  logic [2:0]       cell_wr_data;
  logic [1:0]       cursor_row, cursor_col;
  logic [CNT_W-1:0] revealed_cnt;
  logic             idle, win, lose, timeout, cfg_err;
  logic             ram_init = 1'b1;
  logic [2:0]       mem [ROWS*COLS];

  buscaminas_game_ctrl #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .TURN_CYCLES (TURN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mines_cfg    (mines_cfg),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_reveal   (btn_reveal),
    .btn_flag     (btn_flag),
    .cell_addr    (cell_addr),
    .cell_rd_data (cell_rd_data),
    .cell_wr_en   (cell_wr_en),
    .cell_wr_data (cell_wr_data),
    .cursor_row   (cursor_row),
    .cursor_col   (cursor_col),
    .revealed_cnt (revealed_cnt),
    .idle         (idle),
    .win          (win),
    .lose         (lose),
    .timeout      (timeout),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM model: 1-cycle read latency, single mine at MINE_A.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < ROWS*COLS; i++) mem[i] <= (i == MINE_A) ? 3'b001 : 3'b000;
    end else if (cell_wr_en) begin
      mem[cell_addr] <= cell_wr_data;
    end
    cell_rd_data <= mem[cell_addr];
  end

  function automatic ev_t mk(input int kind, input int addr, input int data, input int tmo, input int c);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.tmo = tmo; e.cyc = c;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic win_q = 1'b0, lose_q = 1'b0;

  task automatic got(input int kind, input int addr, input int data, input int tmo);
    ev_t e;
    vecs++;
    if (sb.size() == 0) begin
      errs++;
      $display("FAIL sb_unexpected: event kind=%0d addr=%0d data=%0d tmo=%0d at cycle %0d, expected no event",
               kind, addr, data, tmo, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          (kind == K_WR && (e.addr != addr || e.data != data)) ||
          (kind == K_LOSE && e.tmo != tmo)) begin
        errs++;
        $display("FAIL sb_event: got kind=%0d cyc=%0d addr=%0d data=%0d tmo=%0d, expected kind=%0d cyc=%0d addr=%0d data=%0d tmo=%0d",
                 kind, cyc, addr, data, tmo, e.kind, e.cyc, e.addr, e.data, e.tmo);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cell_wr_en)    got(K_WR, int'(cell_addr), int'(cell_wr_data), 0);
    if (win && !win_q) got(K_WIN, 0, 0, 0);
    if (lose && !lose_q) got(K_LOSE, 0, 0, int'(timeout));
    if (cfg_err)       got(K_CFG, 0, 0, 0);
    win_q  = win;
    lose_q = lose;
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input int got_v, input int exp_v);
    vecs++;
    if (got_v != exp_v) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, got_v, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic at_cycle(input int x);
    while (cyc < x) begin @(posedge clk); #1; end
  endtask

  // Drive one button high for exactly one cycle; n = cycle it was high.
  task automatic pulse(input int b, output int n);
    @(posedge clk); #1;
    case (b)
      B_REV:   btn_reveal = 1'b1;
      B_FLAG:  btn_flag   = 1'b1;
      B_UP:    btn_up     = 1'b1;
      B_DOWN:  btn_down   = 1'b1;
      B_LEFT:  btn_left   = 1'b1;
      B_RIGHT: btn_right  = 1'b1;
      default: start      = 1'b1;
    endcase
    n = cyc;
    @(posedge clk); #1;
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right, start} = '0;
  endtask

  task automatic mv(input int b, input int er, input int ec);
    int n;
    pulse(b, n);
    chk("cursor_row", int'(cursor_row), er);
    chk("cursor_col", int'(cursor_col), ec);
  endtask

  // Reveal/flag at the cursor; queue an optional write (N+2) and end event (N+3).
  task automatic act(input int b, input bit wr, input int addr, input int data, input int fin, output int n);
    pulse(b, n);
    if (wr) sb.push_back(mk(K_WR, addr, data, 0, n + 2));
    if (fin != 0) sb.push_back(mk(fin, 0, 0, 0, n + 3));
    tick(2);
  endtask

  task automatic start_game(input int mines);
    int n;
    mines_cfg = CNT_W'(mines);
    pulse(B_START, n);
    chk("start_idle", int'(idle), 0);
  endtask

  task automatic end_game();
    int n;
    pulse(B_START, n);
    chk("end_idle", int'(idle), 1);
    chk("end_flags", int'({win, lose, timeout}), 0);
  endtask

  task automatic ram_reset();
    @(posedge clk); #1; ram_init = 1'b1;
    @(posedge clk); #1; ram_init = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, s, a;
    tick(3);
    rst      = 1'b0;
    ram_init = 1'b0;

    // reset state
    chk("rst_idle", int'(idle), 1);
    chk("rst_cursor", int'({cursor_row, cursor_col}), 0);
    chk("rst_cnt", int'(revealed_cnt), 0);
    chk("rst_flags", int'({win, lose, timeout, cfg_err, cell_wr_en}), 0);
    chk("rst_addr", int'(cell_addr), 0);

    // bad mine counts are rejected
    mines_cfg = 5'd16;
    pulse(B_START, n);
    sb.push_back(mk(K_CFG, 0, 0, 0, n + 1));
    tick(1);
    chk("cfg16_idle", int'(idle), 1);
    mines_cfg = 5'd0;
    pulse(B_START, n);
    sb.push_back(mk(K_CFG, 0, 0, 0, n + 1));
    tick(1);
    chk("cfg0_idle", int'(idle), 1);

    // Game A: reveal every safe cell row by row -> win
    start_game(1);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        a = r * COLS + c;
        if (a != MINE_A) act(B_REV, 1'b1, a, 3'b010, (a == 15) ? K_WIN : 0, n);
        if (a != 15) begin
          if (c == COLS - 1) begin
            mv(B_RIGHT, r, 0);
            mv(B_DOWN, r + 1, 0);
          end else begin
            mv(B_RIGHT, r, c + 1);
          end
        end
      end
    end
    chk("win_flag", int'(win), 1);
    chk("win_cnt", int'(revealed_cnt), 15);
    mv(B_UP, 3, 3);
    act(B_REV, 1'b0, 0, 0, 0, n);
    chk("win_cnt_hold", int'(revealed_cnt), 15);
    end_game();

    // Game B: step onto the mine at (1,1)
    ram_reset();
    start_game(1);
    mv(B_DOWN, 1, 0);
    mv(B_RIGHT, 1, 1);
    chk("mine_addr", int'(cell_addr), 5);
    act(B_REV, 1'b1, 5, 3'b011, K_LOSE, n);
    chk("lose_flag", int'(lose), 1);
    chk("lose_tmo", int'(timeout), 0);
    mv(B_UP, 1, 1);
    act(B_FLAG, 1'b0, 0, 0, 0, n);
    chk("lose_hold", int'(lose), 1);
    end_game();

    // Game C: wrap moves, flag then reveal the flagged cell, then idle timeout
    ram_reset();
    start_game(1);
    mv(B_UP, 3, 0);
    mv(B_LEFT, 3, 3);
    chk("wrap_addr", int'(cell_addr), 15);
    mv(B_UP, 2, 3);
    mv(B_LEFT, 2, 2);
    act(B_FLAG, 1'b1, 10, 3'b100, 0, n);
    act(B_REV, 1'b0, 0, 0, 0, n);
    chk("flag_cnt", int'(revealed_cnt), 0);
    chk("flag_ram", int'(mem[10]), 3'b100);
    // PLAY resumes at n+3; the 10th idle PLAY cycle is n+12
    sb.push_back(mk(K_LOSE, 0, 0, 1, n + 13));
    at_cycle(n + 12);
    chk("tmo_early", int'(lose), 0);
    at_cycle(n + 14);
    chk("tmo_lose", int'(lose), 1);
    chk("tmo_flag", int'(timeout), 1);
    end_game();

    // Game D: a move in the 9th idle cycle restarts the count
    ram_reset();
    mines_cfg = 5'd1;
    pulse(B_START, s);
    at_cycle(s + 8);
    pulse(B_RIGHT, n);
    chk("tmo_move_cyc", n, s + 9);
    sb.push_back(mk(K_LOSE, 0, 0, 1, n + 11));
    at_cycle(n + 10);
    chk("tmo_restart", int'(lose), 0);
    at_cycle(n + 12);
    chk("tmo2_lose", int'({lose, timeout}), 3);
    end_game();

    // Game E: reset while in CHECK drops the pending write
    start_game(1);
    pulse(B_REV, n);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_chk_idle", int'(idle), 1);
    chk("rst_chk_wr", int'(cell_wr_en), 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_chk_ram", int'(mem[0]), 0);
    chk("rst_chk_cnt", int'(revealed_cnt), 0);

    tick(4);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
